// File: rtl/decompose_mul_pipe.sv
// Pipelined multiplier with per-transaction signed/unsigned mode, result
// truncation/extension to dout_WIDTH, and overflow detection on the result.
module decompose_mul_pipe #(
  parameter int din0_WIDTH = 31,
  parameter int din1_WIDTH = 33,
  parameter int dout_WIDTH = 44,
  parameter int NUM_STAGE  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int FW   = din0_WIDTH + din1_WIDTH;
  localparam int MW   = (dout_WIDTH > FW) ? dout_WIDTH : FW;
  localparam int LAST = NUM_STAGE - 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is the pipeline advance term, so it never depends on
  // in_valid; out_valid/dout/ovf hold steady until out_ready takes them.
  logic adv;

  logic [FW-1:0]        a_ext;
  logic [FW-1:0]        b_ext;
  logic [FW-1:0]        prod;
  logic [FW-1:0]        prod_q [NUM_STAGE];
  logic                 sg_q   [NUM_STAGE];
  logic [NUM_STAGE-1:0] v_q;
  logic [MW-1:0]        ext;
  logic [dout_WIDTH-1:0] trunc;
  logic                 ovf_c;

  assign out_valid = v_q[LAST];
  assign adv       = ce & ~reset & (~out_valid | out_ready);
  assign in_ready  = adv;

  // Low FW bits of the product of the extended operands are the exact
  // two's-complement product in either mode.
  assign a_ext = is_signed ? FW'($signed(din0)) : FW'(din0);
  assign b_ext = is_signed ? FW'($signed(din1)) : FW'(din1);
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < NUM_STAGE; k++) v_q[k] <= v_q[k-1];
    end
  end

  // Data stages carry no reset; the valid bits decide what is meaningful.
  always_ff @(posedge clk) begin
    if (adv) begin
      prod_q[0] <= prod;
      sg_q[0]   <= is_signed;
      for (int k = 1; k < NUM_STAGE; k++) begin
        prod_q[k] <= prod_q[k-1];
        sg_q[k]   <= sg_q[k-1];
      end
    end
  end

  assign ext = sg_q[LAST] ? MW'($signed(prod_q[LAST])) : MW'(prod_q[LAST]);

  always_comb begin
    trunc = ext[dout_WIDTH-1:0];
    ovf_c = 1'b0;
    // Only bits above dout_WIDTH are discarded; none exist when MW == dout_WIDTH.
    for (int i = dout_WIDTH; i < MW; i++) begin
      if (sg_q[LAST] ? (ext[i] != ext[dout_WIDTH-1]) : ext[i]) ovf_c = 1'b1;
    end
  end

  // Gating on out_valid makes reset clear dout/ovf without waiting for a clock.
  assign dout = out_valid ? trunc : '0;
  assign ovf  = out_valid & ovf_c;

endmodule

// File: tb/tb_decompose_mul_pipe.sv
// Directed bench for decompose_mul_pipe at default parameters (31x33 -> 44, 2 stages).
module tb_decompose_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] din0;
  logic [32:0] din1;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [43:0] dout;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  logic [43:0] exp_q[$];

  decompose_mul_pipe dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge with ce=1, out_ready=1. Checks 2-stage latency.
  task automatic run_one(input string tag, input logic [30:0] a, input logic [32:0] b,
                         input logic s, input logic [43:0] exp_d, input logic exp_o);
    din0 = a; din1 = b; is_signed = s; in_valid = 1'b1;
    #1;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_lat"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_dout"}, 64'(dout), 64'(exp_d));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
  endtask

  logic [30:0] sa [4];
  logic [32:0] sb [4];

  initial begin
    int idx;
    int got;
    int seen;
    logic acc;
    logic tk;

    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0;
    is_signed = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd0);
    #2 reset = 1'b0;
    step();

    // Directed products
    run_one("u3x5", 31'd3, 33'd5, 1'b0, 44'd15, 1'b0);
    run_one("s_m1x5", 31'h7FFFFFFF, 33'd5, 1'b1, 44'hFFFFFFFFFFB, 1'b0);
    // (2^31-1)*5 = 0x27FFFFFFB fits in 44 bits unsigned
    run_one("u_7fx5", 31'h7FFFFFFF, 33'd5, 1'b0, 44'h0027FFFFFFB, 1'b0);
    run_one("u_2p62", 31'h40000000, 33'h100000000, 1'b0, 44'd0, 1'b1);
    run_one("s_m1xm1", 31'h7FFFFFFF, 33'h1FFFFFFFF, 1'b1, 44'd1, 1'b0);
    // -2^30 * 4 = -2^32
    run_one("s_neg", 31'h40000000, 33'd4, 1'b1, 44'hFFF00000000, 1'b0);
    // (2^30-1)*(2^32-1) overflows signed 44 bits
    run_one("s_ovf", 31'h3FFFFFFF, 33'h0FFFFFFFF, 1'b1, 44'hFFEC0000001, 1'b1);
    run_one("u_zero", 31'd0, 33'h1FFFFFFFF, 1'b0, 44'd0, 1'b0);
    step();
    check("drain_vld", 64'(out_valid), 64'd0);

    // Back-to-back stream with downstream stall
    for (int i = 0; i < 4; i++) begin
      sa[i] = 31'(i * 3 + 1);
      sb[i] = 33'(i + 2);
    end
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid  = (idx < 4);
      din0      = sa[idx < 4 ? idx : 3];
      din1      = sb[idx < 4 ? idx : 3];
      is_signed = 1'b0;
      out_ready = (cyc == 0) || (cyc >= 6);
      #1;
      acc = in_valid & in_ready;
      tk  = out_valid & out_ready;
      if (cyc >= 2 && cyc < 6) begin
        check("stall_rdy", 64'(in_ready), 64'd0);
        check("stall_dout", 64'(dout), 64'd1 * 64'd2);
      end
      if (tk) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 64'd1, 64'd0);
        end else begin
          check("stream_dout", 64'(dout), 64'(exp_q.pop_front()));
          got++;
        end
      end
      if (acc) begin
        exp_q.push_back(44'(sa[idx]) * 44'(sb[idx]));
        idx++;
      end
      step();
    end
    in_valid = 1'b0;
    check("stream_cnt", 64'(got), 64'd4);
    out_ready = 1'b1;
    step();
    check("stream_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    din0 = 31'h40000000; din1 = 33'h100000000; is_signed = 1'b0; in_valid = 1'b1;
    step();
    din0 = 31'd9; din1 = 33'd9;
    step();
    in_valid = 1'b0;
    check("pre_rst_vld", 64'(out_valid), 64'd1);
    check("pre_rst_ovf", 64'(ovf), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_vld", 64'(out_valid), 64'd0);
    check("arst_dout", 64'(dout), 64'd0);
    check("arst_ovf", 64'(ovf), 64'd0);
    check("arst_rdy", 64'(in_ready), 64'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("post_rst_ghost", 64'(seen), 64'd0);

    // Clock-enable freeze for three cycles
    din0 = 31'd6; din1 = 33'd7; is_signed = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ce_hold_vld", 64'(out_valid), 64'd0);
      check("ce_hold_rdy", 64'(in_ready), 64'd0);
    end
    ce = 1'b1;
    step();
    check("ce_vld", 64'(out_valid), 64'd1);
    check("ce_dout", 64'(dout), 64'd42);
    step();
    check("ce_drain", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
